shift_collector: RTL and testbench

//  Decoder-side counterpart of the coder's timed shift chain: accepts a serial

---
 rtl/coder_pkg.sv | 23 ++
 rtl/stride_timer.sv | 51 +++++
 rtl/shift_collector.sv | 112 +++++++++++
 tb/tb_shift_collector.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : coder_pkg
//  Purpose  : Shared definitions for the encoder-side shift chain and the
//             decoder-side shift collector: the serial sample type, default
//             geometry/pacing constants and a counter-width helper.
//  Revision : 1.0 - initial release
// ============================================================================
package coder_pkg;

  localparam int C_DATA_WIDTH = 8;  // bits per serial sample
  localparam int C_DEPTH      = 5;  // samples per assembled word
  localparam int C_TIMING     = 4;  // minimum cycles between samples

  typedef logic [C_DATA_WIDTH-1:0] sample_t;

  // Width of a counter that holds 0..range_n-1; never narrower than one bit.
  function automatic int cnt_width(input int range_n);
    return (range_n > 1) ? $clog2(range_n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stride_timer.sv
`default_nettype none
// ============================================================================
//  Module   : stride_timer
//  Purpose  : Pacing down-counter shared by the paced coder blocks. A load
//             starts a TIMING-1 cycle holdoff; idle is high once it expires.
//  Ports    : clk   - clock, rising edge
//             rst_n - asynchronous active-low reset (counter to 0)
//             clear - synchronous return to idle
//             load  - start a new holdoff (only meaningful while idle)
//             idle  - counter is zero, a new event may be taken
//  Revision : 1.0 - initial release
// ============================================================================
module stride_timer
  import coder_pkg::*;
#(
  parameter int TIMING = C_TIMING
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load,
  output logic idle
);

  localparam int TW = cnt_width(TIMING);

  logic [TW-1:0] r_count;

  generate
    if (TIMING > 1) begin : g_paced
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_count <= '0;
        end else if (clear) begin
          r_count <= '0;
        end else if (load) begin
          r_count <= TW'(TIMING - 1);
        end else if (r_count != '0) begin
          r_count <= r_count - TW'(1);
        end
      end
    end else begin : g_unpaced
      // Every cycle is eligible; there is nothing to count.
      assign r_count = '0;
    end
  endgenerate

  assign idle = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/shift_collector.sv
`default_nettype none
// ============================================================================
//  Module   : shift_collector
//  Purpose  : Collects DEPTH paced serial samples into one parallel word and
//             presents it through a one-word valid/ready holding register.
//             The first sample of a word lands in the least significant slot.
//  Ports    : clk, rst_n          - clock / async active-low reset
//             clear               - drop partial word, restart pacing
//             in_valid/in_ready/in    - serial sample handshake
//             out_valid/out_ready/out - assembled word handshake
//  Revision : 1.0 - initial release
// ============================================================================
module shift_collector
  import coder_pkg::*;
#(
  parameter int DATA_WIDTH = C_DATA_WIDTH,
  parameter int DEPTH      = C_DEPTH,
  parameter int TIMING     = C_TIMING
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DEPTH*DATA_WIDTH-1:0] out
);

  localparam int            IW         = cnt_width(DEPTH);
  localparam logic [IW-1:0] C_LAST_IDX = IW'(DEPTH - 1);

  logic [IW-1:0]               r_idx;
  logic [DEPTH*DATA_WIDTH-1:0] r_out;
  logic                        r_out_valid;
  logic [DEPTH*DATA_WIDTH-1:0] w_word;
  logic                        w_idle;
  logic                        w_last;
  logic                        w_stall;
  logic                        w_in_ready;
  logic                        w_accept;
  logic                        w_load_word;

  stride_timer #(
    .TIMING (TIMING)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .load  (w_accept),
    .idle  (w_idle)
  );

  assign w_last = (r_idx == C_LAST_IDX);
  // Only the word-completing sample needs room in the holding register; a
  // drain in the same cycle frees that room.
  assign w_stall     = w_last && r_out_valid && !out_ready;
  assign w_in_ready  = rst_n && w_idle && !clear && !w_stall;
  assign w_accept    = in_valid && w_in_ready;
  assign w_load_word = w_accept && w_last;

  // Slot registers for samples 0..DEPTH-2; the final sample is taken
  // straight from the input when the word is loaded.
  generate
    for (genvar k = 0; k < DEPTH - 1; k++) begin : g_slot
      logic [DATA_WIDTH-1:0] r_slot;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_slot <= '0;
        end else if (w_accept && (r_idx == IW'(k))) begin
          r_slot <= in;
        end
      end

      assign w_word[k*DATA_WIDTH +: DATA_WIDTH] = r_slot;
    end
  endgenerate

  assign w_word[(DEPTH-1)*DATA_WIDTH +: DATA_WIDTH] = in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (clear) begin
      r_idx <= '0;
    end else if (w_accept) begin
      r_idx <= w_last ? '0 : r_idx + IW'(1);
    end
  end

  // Holding register: a new word wins over a drain, so back-to-back words
  // keep out_valid high without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load_word) begin
      r_out       <= w_word;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out       = r_out;

endmodule
`default_nettype wire

// File: tb/tb_shift_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_collector
//  Purpose  : Self-checking bench for shift_collector. One instance runs with
//             TIMING=4, one with TIMING=1 (both DEPTH=5, DATA_WIDTH=8).
//             Expected words are queued as stimulus is driven and compared as
//             the DUT hands them off.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_collector;

  localparam int DW = 8;
  localparam int DP = 5;
  localparam int OW = DW * DP;

  logic          clk;
  logic          rst_n;

  logic          clear4, in_valid4, in_ready4, out_valid4, out_ready4;
  logic [DW-1:0] in4;
  logic [OW-1:0] out4;

  logic          clear1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [DW-1:0] in1;
  logic [OW-1:0] out1;

  int tests;
  int fails;

  logic [OW-1:0] q4[$];
  logic [OW-1:0] q1[$];

  shift_collector #(.DATA_WIDTH(DW), .DEPTH(DP), .TIMING(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear4), .in_valid(in_valid4),
    .in_ready(in_ready4), .in(in4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out(out4)
  );

  shift_collector #(.DATA_WIDTH(DW), .DEPTH(DP), .TIMING(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1), .in_valid(in_valid1),
    .in_ready(in_ready1), .in(in1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out(out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word whose slot k holds base+k (e.g. mkword(1) == {5,4,3,2,1}).
  function automatic logic [OW-1:0] mkword(input int base);
    logic [OW-1:0] w;
    w = '0;
    for (int k = 0; k < DP; k++) w[k*DW +: DW] = DW'(base + k);
    return w;
  endfunction

  // Scoreboard monitors: a handshake seen at the falling edge completes at
  // the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid4 && out_ready4) begin
      tests++;
      if (q4.size() == 0) begin
        fails++;
        $display("FAIL sb4_unexpected: out=%h with no word expected", out4);
      end else begin
        logic [OW-1:0] e;
        e = q4.pop_front();
        if (out4 !== e) begin
          fails++;
          $display("FAIL sb4_word: got %h expected %h", out4, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid1 && out_ready1) begin
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL sb1_unexpected: out=%h with no word expected", out1);
      end else begin
        logic [OW-1:0] e;
        e = q1.pop_front();
        if (out1 !== e) begin
          fails++;
          $display("FAIL sb1_word: got %h expected %h", out1, e);
        end
      end
    end
  end

  // Drive one sample into dut4 and wait (bounded) until it is taken.
  // Entered and left just after a rising edge.
  task automatic send4(input int val);
    bit done;
    done = 1'b0;
    in4 = DW'(val);
    in_valid4 = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready4) done = 1'b1;
      @(posedge clk); #1;
    end
    in_valid4 = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send4_timeout: sample %0d never accepted", val);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    tests++;
    if (out_valid4 !== 1'b0 || out4 !== '0 || in_ready4 !== 1'b0) begin
      fails++;
      $display("FAIL reset4: out_valid=%b out=%h in_ready=%b expected 0 0 0",
               out_valid4, out4, in_ready4);
    end
    tests++;
    if (out_valid1 !== 1'b0 || out1 !== '0 || in_ready1 !== 1'b0) begin
      fails++;
      $display("FAIL reset1: out_valid=%b out=%h in_ready=%b expected 0 0 0",
               out_valid1, out1, in_ready1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_pacing4;
    int n;
    bit acc;
    n = 0;
    out_ready4 = 1'b1;
    in4 = 8'd1;
    in_valid4 = 1'b1;
    q4.push_back(mkword(1));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      tests++;
      if (in_ready4 !== ((c % 4 == 0) && (c <= 16))) begin
        fails++;
        $display("FAIL pace4_ready: cycle %0d in_ready=%b expected %b",
                 c, in_ready4, ((c % 4 == 0) && (c <= 16)));
      end
      tests++;
      if (out_valid4 !== (c == 17)) begin
        fails++;
        $display("FAIL pace4_valid: cycle %0d out_valid=%b expected %b",
                 c, out_valid4, (c == 17));
      end
      acc = in_valid4 && in_ready4;
      if (acc) n++;
      @(posedge clk); #1;
      if (acc) begin
        if (n == DP) in_valid4 = 1'b0;
        else         in4 = DW'(n + 1);
      end
    end
  endtask

  task automatic test_back_to_back;
    out_ready1 = 1'b1;
    q1.push_back(mkword(1));
    q1.push_back(mkword(6));
    for (int c = 0; c < 12; c++) begin
      in_valid1 = (c < 10);
      in1 = DW'(c + 1);
      @(negedge clk);
      tests++;
      if (in_ready1 !== 1'b1) begin
        fails++;
        $display("FAIL b2b_ready: cycle %0d in_ready=%b expected 1", c, in_ready1);
      end
      tests++;
      if (out_valid1 !== ((c == 5) || (c == 10))) begin
        fails++;
        $display("FAIL b2b_valid: cycle %0d out_valid=%b expected %b",
                 c, out_valid1, ((c == 5) || (c == 10)));
      end
      @(posedge clk); #1;
    end
    in_valid1 = 1'b0;
  endtask

  task automatic test_stall;
    int n;
    n = 0;
    q1.push_back(mkword(1));
    q1.push_back(mkword(6));
    for (int c = 0; c < 15; c++) begin
      in_valid1  = (n < 10);
      in1        = DW'(n + 1);
      out_ready1 = (c >= 12);
      @(negedge clk);
      if (c >= 9 && c <= 11) begin
        tests++;
        if (in_ready1 !== 1'b0) begin
          fails++;
          $display("FAIL stall_ready: cycle %0d in_ready=%b expected 0", c, in_ready1);
        end
        tests++;
        if (out_valid1 !== 1'b1 || out1 !== mkword(1)) begin
          fails++;
          $display("FAIL stall_hold: cycle %0d out_valid=%b out=%h expected 1 %h",
                   c, out_valid1, out1, mkword(1));
        end
      end else if (c <= 12) begin
        tests++;
        if (in_ready1 !== 1'b1) begin
          fails++;
          $display("FAIL stall_accept: cycle %0d in_ready=%b expected 1", c, in_ready1);
        end
      end
      if (in_valid1 && in_ready1) n++;
      @(posedge clk); #1;
    end
    in_valid1 = 1'b0;
    tests++;
    if (n !== 10) begin
      fails++;
      $display("FAIL stall_count: accepted %0d samples expected 10", n);
    end
  endtask

  task automatic test_clear;
    out_ready4 = 1'b0;
    q4.push_back(mkword(10));
    for (int v = 10; v < 15; v++) send4(v);
    for (int v = 1; v < 4; v++) send4(v);
    // Timer is mid-holdoff here; clear must both block and restart pacing.
    clear4 = 1'b1;
    in4 = 8'd99;
    in_valid4 = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready4 !== 1'b0) begin
      fails++;
      $display("FAIL clear_block: in_ready=%b expected 0", in_ready4);
    end
    @(posedge clk); #1;
    clear4 = 1'b0;
    in_valid4 = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready4 !== 1'b1) begin
      fails++;
      $display("FAIL clear_timer: in_ready=%b expected 1", in_ready4);
    end
    tests++;
    if (out_valid4 !== 1'b1 || out4 !== mkword(10)) begin
      fails++;
      $display("FAIL clear_pending: out_valid=%b out=%h expected 1 %h",
               out_valid4, out4, mkword(10));
    end
    @(posedge clk); #1;
    for (int v = 20; v < 24; v++) send4(v);
    in4 = 8'd24;
    in_valid4 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tests++;
      if (in_ready4 !== 1'b0) begin
        fails++;
        $display("FAIL clear_stall: wait %0d in_ready=%b expected 0", c, in_ready4);
      end
      @(posedge clk); #1;
    end
    out_ready4 = 1'b1;
    q4.push_back(mkword(20));
    send4(24);
    for (int c = 0; c < 3; c++) @(posedge clk);
    #1;
  endtask

  task automatic test_midword_reset;
    out_ready4 = 1'b0;
    for (int v = 30; v < 35; v++) send4(v);
    send4(40);
    send4(41);
    @(negedge clk);
    tests++;
    if (out_valid4 !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre: out_valid=%b expected 1", out_valid4);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid4 !== 1'b0 || out4 !== '0 || in_ready4 !== 1'b0) begin
      fails++;
      $display("FAIL rst_async: out_valid=%b out=%h in_ready=%b expected 0 0 0",
               out_valid4, out4, in_ready4);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b1;
    @(negedge clk);
    tests++;
    if (out_valid4 !== 1'b0) begin
      fails++;
      $display("FAIL rst_spurious: out_valid=%b expected 0", out_valid4);
    end
    @(posedge clk); #1;
    q4.push_back(mkword(50));
    for (int v = 50; v < 55; v++) send4(v);
    for (int c = 0; c < 3; c++) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    clear4 = 1'b0; in_valid4 = 1'b0; in4 = '0; out_ready4 = 1'b0;
    clear1 = 1'b0; in_valid1 = 1'b0; in1 = '0; out_ready1 = 1'b0;

    test_reset();
    test_pacing4();
    test_back_to_back();
    test_stall();
    test_clear();
    test_midword_reset();

    tests++;
    if (q4.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d/%0d words never produced", q4.size(), q1.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
